// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the unified-memory arbiter.
//   ProgramCounter : 32-bit address type used for fetch addresses
//   Signal         : single-bit control type
//   ArbState       : arbiter FSM states
//   Requester      : which port owns the current memory transaction
//   TIMEOUT_DATA   : read data returned when memory never acknowledges
package mem_arbiter_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned WAIT_W = 4;

    typedef logic [XLEN-1:0] ProgramCounter;
    typedef logic            Signal;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2,
        RESP    = 2'd3
    } ArbState;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_DM = 1'b1
    } Requester;

    localparam logic [XLEN-1:0] TIMEOUT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch (IF)
// and data memory (DM) requesters, with a wait-cycle timeout.
// Ports:
//   clk, rst (async, active-low)
//   if_req/if_addr -> if_rdata/if_ready          : fetch requester
//   dm_read/dm_write/dm_addr/dm_wdata
//                  -> dm_rdata/dm_ready          : data requester
//   mem_en/mem_we/mem_addr/mem_wdata,
//   mem_rdata/mem_ack                            : unified memory
//   stall_if/stall_m (combinational)             : pipeline stalls
//   err                                          : sticky timeout flag
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  ProgramCounter if_addr,
    output logic [31:0]   if_rdata,
    output logic          if_ready,
    input  logic          dm_read,
    input  logic          dm_write,
    input  logic [31:0]   dm_addr,
    input  logic [31:0]   dm_wdata,
    output logic [31:0]   dm_rdata,
    output logic          dm_ready,
    output logic          mem_en,
    output logic          mem_we,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    input  logic          mem_ack,
    output logic          stall_if,
    output logic          stall_m,
    output logic          err
);

    ArbState             state_q,     state_d;
    Requester            last_q,      last_d;
    logic                mem_en_q,    mem_en_d;
    logic                mem_we_q,    mem_we_d;
    logic [XLEN-1:0]     mem_addr_q,  mem_addr_d;
    logic [XLEN-1:0]     mem_wdata_q, mem_wdata_d;
    logic [XLEN-1:0]     if_rdata_q,  if_rdata_d;
    logic [XLEN-1:0]     dm_rdata_q,  dm_rdata_d;
    logic                if_ready_q,  if_ready_d;
    logic                dm_ready_q,  dm_ready_d;
    logic                err_q,       err_d;
    logic [WAIT_W-1:0]   wait_q,      wait_d;

    logic                dm_pend_c;
    logic [WAIT_W-1:0]   wait_inc_c;
    logic                busy_c;
    logic                timeout_c;
    logic [XLEN-1:0]     resp_data_c;

    assign dm_pend_c  = dm_read | dm_write;
    assign wait_inc_c = wait_q + WAIT_W'(1);
    assign busy_c     = (state_q == BUSY_IF) || (state_q == BUSY_DM);
    // Timeout fires in the BUSY cycle whose miss would bring the count to MAX_WAIT,
    // so mem_en is held for exactly MAX_WAIT cycles.
    assign timeout_c  = busy_c && !mem_ack && (wait_inc_c == WAIT_W'(MAX_WAIT));
    assign resp_data_c = mem_ack ? mem_rdata : TIMEOUT_DATA;

    // Next-state, grant and capture logic
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_ready_d  = 1'b0;
        dm_ready_d  = 1'b0;
        err_d       = err_q;
        wait_d      = wait_q;

        case (state_q)
            IDLE: begin
                // DM wins unless IF is also pending and DM was served last
                if (dm_pend_c && (!if_req || (last_q == REQ_IF))) begin
                    state_d     = BUSY_DM;
                    last_d      = REQ_DM;
                    mem_en_d    = 1'b1;
                    mem_we_d    = dm_write;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                    wait_d      = '0;
                end else if (if_req) begin
                    state_d     = BUSY_IF;
                    last_d      = REQ_IF;
                    mem_en_d    = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    wait_d      = '0;
                end
            end
            BUSY_IF, BUSY_DM: begin
                if (mem_ack || timeout_c) begin
                    state_d  = RESP;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    if (timeout_c) begin
                        err_d = 1'b1;
                    end
                    if (state_q == BUSY_IF) begin
                        if_rdata_d = resp_data_c;
                        if_ready_d = 1'b1;
                    end else begin
                        // Stores leave the load data untouched
                        if (!mem_we_q) begin
                            dm_rdata_d = resp_data_c;
                        end
                        dm_ready_d = 1'b1;
                    end
                end else begin
                    wait_d = wait_inc_c;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Single state register for FSM, data latches and wait counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            last_q      <= REQ_IF;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_ready_q  <= 1'b0;
            dm_ready_q  <= 1'b0;
            err_q       <= 1'b0;
            wait_q      <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_ready_q  <= if_ready_d;
            dm_ready_q  <= dm_ready_d;
            err_q       <= err_d;
            wait_q      <= wait_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_ready  = if_ready_q;
    assign dm_ready  = dm_ready_q;
    assign err       = err_q;

    // Stalls are combinational so the pipeline freezes in the request cycle itself
    assign stall_if = if_req & ~if_ready_q;
    assign stall_m  = dm_pend_c & ~dm_ready_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        dm_read;
    logic        dm_write;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        stall_if;
    logic        stall_m;
    logic        err;

    int n_checks;
    int n_fail;

    mem_arbiter #(.MAX_WAIT(15)) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_ready (if_ready),
        .dm_read  (dm_read),
        .dm_write (dm_write),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_rdata (dm_rdata),
        .dm_ready (dm_ready),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack),
        .stall_if (stall_if),
        .stall_m  (stall_m),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cyc;
        int en_cnt;
        bit got_ready;

        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b0;
        if_req    = 1'b0;
        if_addr   = '0;
        dm_read   = 1'b0;
        dm_write  = 1'b0;
        dm_addr   = '0;
        dm_wdata  = '0;
        mem_rdata = '0;
        mem_ack   = 1'b0;

        // Reset state
        step();
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_dm_rdata", dm_rdata, 0);
        check("rst_if_ready", if_ready, 0);
        check("rst_dm_ready", dm_ready, 0);
        check("rst_err", err, 0);
        #2 rst = 1'b1;

        // Fetch only: ack two cycles after mem_en, ready at cycle 4
        step();
        if_req = 1'b1; if_addr = 32'h40;
        #1;
        check("f_c0_stall", stall_if, 1);
        check("f_c0_en", mem_en, 0);
        step();
        check("f_c1_en", mem_en, 1);
        check("f_c1_addr", mem_addr, 32'h40);
        check("f_c1_we", mem_we, 0);
        check("f_c1_stall", stall_if, 1);
        step();
        check("f_c2_en", mem_en, 1);
        check("f_c2_stall", stall_if, 1);
        step();
        mem_ack = 1'b1; mem_rdata = 32'h8C220004;
        check("f_c3_en", mem_en, 1);
        check("f_c3_ready", if_ready, 0);
        check("f_c3_stall", stall_if, 1);
        step();
        mem_ack = 1'b0;
        check("f_c4_ready", if_ready, 1);
        check("f_c4_rdata", if_rdata, 32'h8C220004);
        check("f_c4_en", mem_en, 0);
        check("f_c4_stall", stall_if, 0);
        if_req = 1'b0;
        step();
        check("f_c5_ready", if_ready, 0);
        check("f_c5_rdata_hold", if_rdata, 32'h8C220004);

        // Store with dm_read also high: store wins, ack on first BUSY cycle
        dm_write = 1'b1; dm_read = 1'b1; dm_addr = 32'h100; dm_wdata = 32'h12345678;
        step();
        check("s_c1_en", mem_en, 1);
        check("s_c1_we", mem_we, 1);
        check("s_c1_addr", mem_addr, 32'h100);
        check("s_c1_wdata", mem_wdata, 32'h12345678);
        check("s_c1_stall_m", stall_m, 1);
        mem_ack = 1'b1; mem_rdata = 32'hAAAA5555;
        step();
        mem_ack = 1'b0;
        check("s_c2_ready", dm_ready, 1);
        check("s_c2_rdata_kept", dm_rdata, 0);
        check("s_c2_en", mem_en, 0);
        check("s_c2_stall_m", stall_m, 0);
        dm_write = 1'b0; dm_read = 1'b0;
        step();
        check("s_c3_ready", dm_ready, 0);

        // Fetch request dropped mid-transaction still completes with a ready pulse
        if_req = 1'b1; if_addr = 32'h500;
        step();
        check("d_c1_en", mem_en, 1);
        if_req = 1'b0;
        step();
        mem_ack = 1'b1; mem_rdata = 32'h00000055;
        step();
        mem_ack = 1'b0;
        check("d_ready", if_ready, 1);
        check("d_rdata", if_rdata, 32'h55);
        step();

        // Both requesters from reset: DM first, then alternate
        rst = 1'b0;
        if_req = 1'b1; if_addr = 32'h80;
        dm_read = 1'b1; dm_addr = 32'h200;
        step();
        #2 rst = 1'b1;
        for (int t = 0; t < 4; t++) begin
            bit is_dm;
            is_dm = (t % 2) == 0;
            step();
            check("rr_en", mem_en, 1);
            check("rr_addr", mem_addr, is_dm ? 32'h200 : 32'h80);
            check("rr_we", mem_we, 0);
            mem_ack = 1'b1; mem_rdata = 32'(32'h1000 + t);
            step();
            mem_ack = 1'b0;
            check("rr_resp_en", mem_en, 0);
            check("rr_dm_ready", dm_ready, is_dm ? 1 : 0);
            check("rr_if_ready", if_ready, is_dm ? 0 : 1);
            if (is_dm) check("rr_dm_rdata", dm_rdata, 32'(32'h1000 + t));
            else       check("rr_if_rdata", if_rdata, 32'(32'h1000 + t));
            step();
            check("rr_idle_dm_ready", dm_ready, 0);
            check("rr_idle_if_ready", if_ready, 0);
        end

        // Load with no ack: timeout after 15 mem_en cycles
        if_req = 1'b0; dm_addr = 32'h300;
        check("to_err_before", err, 0);
        cyc = 0; en_cnt = 0; got_ready = 1'b0;
        while (cyc < 40 && !got_ready) begin
            step();
            cyc++;
            if (dm_ready) got_ready = 1'b1;
            else if (mem_en) en_cnt++;
        end
        check("to_ready_cycle", 32'(cyc), 16);
        check("to_en_cycles", 32'(en_cnt), 15);
        check("to_rdata", dm_rdata, 32'hDEADBEEF);
        check("to_err", err, 1);
        check("to_en_off", mem_en, 0);
        dm_read = 1'b0;
        step();
        check("to_ready_drop", dm_ready, 0);
        step();
        step();
        check("to_err_sticky", err, 1);

        // Reset in the middle of a DM transaction
        dm_read = 1'b1; dm_addr = 32'h400;
        step();
        check("r_c1_en", mem_en, 1);
        step();
        #3 rst = 1'b0;
        #1;
        check("r_async_en", mem_en, 0);
        check("r_async_ready", dm_ready, 0);
        check("r_async_err", err, 0);
        check("r_async_rdata", dm_rdata, 0);
        step();
        check("r_held_en", mem_en, 0);
        check("r_held_ready", dm_ready, 0);
        #2 rst = 1'b1;
        step();
        check("r_regrant_en", mem_en, 1);
        check("r_regrant_addr", mem_addr, 32'h400);
        mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        step();
        mem_ack = 1'b0;
        check("r_ready", dm_ready, 1);
        check("r_rdata", dm_rdata, 32'hCAFEF00D);
        dm_read = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
